// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared FSM encoding, button indices and owner arbitration for button_strobe_gen
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  localparam int NUM_BTN   = 3;
  localparam int BTN_FUNCT = 0;
  localparam int BTN_AUM   = 1;
  localparam int BTN_DIS   = 2;

  // One-hot owner pick; function select wins, then increase, then decrease.
  function automatic logic [NUM_BTN-1:0] pick_owner(input logic [NUM_BTN-1:0] lvl);
    logic [NUM_BTN-1:0] oh;
    oh = '0;
    if (lvl[BTN_FUNCT]) begin
      oh[BTN_FUNCT] = 1'b1;
    end else if (lvl[BTN_AUM]) begin
      oh[BTN_AUM] = 1'b1;
    end else if (lvl[BTN_DIS]) begin
      oh[BTN_DIS] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - 2-flop synchronizer followed by a consecutive-cycle debouncer
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // cnt tracks how many consecutive cycles the synchronized input has disagreed with level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_q2 == level) begin
      cnt <= '0;
    end else if (cnt >= CNT_LAST) begin
      level <= sync_q2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/button_strobe_gen.sv
// rtl/button_strobe_gen.sv - debounced three-button command strobe generator with auto-repeat
module button_strobe_gen
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn_aumentar,
  input  logic btn_disminuir,
  input  logic btn_funct,
  output logic aumentar,
  output logic disminuir,
  output logic funct_select,
  output logic chip_select
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;
  // HOLD is entered one edge after EMIT with the counter at zero, hence the -2.
  localparam logic [RPT_W-1:0] DELAY_HIT = RPT_W'(REPEAT_DELAY - 2);
  localparam logic [RPT_W-1:0] RATE_HIT  = RPT_W'(REPEAT_RATE - 2);
  localparam logic [RPT_W-1:0] RPT_SAT   = '1;

  logic [NUM_BTN-1:0] raw_btn;
  logic [NUM_BTN-1:0] lvl;

  assign raw_btn[BTN_FUNCT] = btn_funct;
  assign raw_btn[BTN_AUM]   = btn_aumentar;
  assign raw_btn[BTN_DIS]   = btn_disminuir;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_btn[i]),
      .level(lvl[i])
    );
  end

  state_t             state;
  state_t             state_nxt;
  logic [NUM_BTN-1:0] owner;
  logic [NUM_BTN-1:0] owner_nxt;
  logic               first_rpt;
  logic [RPT_W-1:0]   rpt_cnt;
  logic               rpt_hit;
  logic               owner_rpts;

  assign owner_rpts = owner[BTN_AUM] | owner[BTN_DIS];
  assign rpt_hit    = first_rpt ? (rpt_cnt >= DELAY_HIT) : (rpt_cnt >= RATE_HIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    chip_select  = 1'b0;
    aumentar     = 1'b0;
    disminuir    = 1'b0;
    funct_select = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!enable) begin
          state_nxt = ST_WAIT_REL;
        end else if (|lvl) begin
          state_nxt = ST_EMIT;
          owner_nxt = pick_owner(lvl);
        end
      end
      ST_EMIT: begin
        chip_select  = 1'b1;
        aumentar     = owner[BTN_AUM];
        disminuir    = owner[BTN_DIS];
        funct_select = owner[BTN_FUNCT];
        state_nxt    = enable ? ST_HOLD : ST_WAIT_REL;
      end
      ST_HOLD: begin
        if (!enable || !(|(lvl & owner))) begin
          state_nxt = ST_WAIT_REL;
        end else if (owner_rpts && rpt_hit) begin
          state_nxt = ST_EMIT;
        end
      end
      ST_WAIT_REL: begin
        if (enable && !(|lvl)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= '0;
      first_rpt <= 1'b0;
      rpt_cnt   <= '0;
    end else begin
      owner <= owner_nxt;
      if (state == ST_IDLE) begin
        first_rpt <= 1'b1;
      end else if (state == ST_HOLD && state_nxt == ST_EMIT) begin
        first_rpt <= 1'b0;
      end
      if (state == ST_EMIT) begin
        rpt_cnt <= '0;
      end else if (state == ST_HOLD && rpt_cnt != RPT_SAT) begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
  end

endmodule

// File: doc/button_strobe_gen.md
BUTTON_STROBE_GEN -- requirements
Module: button_strobe_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); legal range ≥2.
REQ-002 Parameter REPEAT_DELAY, default 25000000: cycles from an initial strobe to the first auto-repeat strobe; legal range ≥2.
REQ-003 Parameter REPEAT_RATE, default 10000000: cycles between subsequent auto-repeat strobes; legal range ≥2.
REQ-004 clk  input  1  system clock; the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  system reset; asynchronous, active-low (0 = reset asserted).
REQ-006 enable  input  1  1 = strobes permitted; 0 = no strobes issued.
REQ-007 btn_aumentar  input  1  raw "increase" push button, asynchronous, active-high.
REQ-008 btn_disminuir  input  1  raw "decrease" push button, asynchronous, active-high.
REQ-009 btn_funct  input  1  raw "function select" push button, asynchronous, active-high.
REQ-010 aumentar  output  1  one-hot command bit, valid only while chip_select=1.
REQ-011 disminuir  output  1  one-hot command bit, valid only while chip_select=1.
REQ-012 funct_select  output  1  one-hot command bit, valid only while chip_select=1.
REQ-013 chip_select  output  1  single-cycle load strobe for the downstream input register.

Function
REQ-014 Each raw button SHALL pass a 2-flop synchronizer, then a debouncer whose stable level flips only after DEBOUNCE_CYCLES consecutive cycles of synchronized level differing from it; any agreeing cycle clears the counter.
REQ-015 FSM states SHALL be IDLE, EMIT, HOLD, WAIT_REL.
REQ-016 IDLE: if enable=1 and any debounced button is high, the FSM SHALL capture one owner (priority funct > aumentar > disminuir) and go to EMIT; otherwise stay.
REQ-017 EMIT (exactly 1 cycle): chip_select=1 and only the owner's command bit =1; next state HOLD with repeat counter cleared.
REQ-018 Outside EMIT, chip_select, aumentar, disminuir, funct_select SHALL all be 0.
REQ-019 HOLD: if owner debounced level falls, go WAIT_REL; else if owner is aumentar/disminuir and counter reaches REPEAT_DELAY (first repeat) or REPEAT_RATE (later repeats), go EMIT; funct owner never repeats.
REQ-020 Strobe spacing SHALL be exactly REPEAT_DELAY cycles from initial to first repeat and exactly REPEAT_RATE cycles between repeats, rising edge to rising edge.
REQ-021 WAIT_REL: SHALL stay until all three debounced levels are 0, then go IDLE; presses of other buttons during ownership never generate strobes.
REQ-022 enable=0 in any state SHALL force WAIT_REL on the next edge (EMIT still completes its single cycle).
REQ-023 Latency: with raw first sampled high at edge 0 and stable, chip_select SHALL be high in the cycle following edge DEBOUNCE_CYCLES+2.
REQ-024 Release latency: owner debounced fall SHALL be recognized by the debouncer DEBOUNCE_CYCLES+2 edges after raw falls, with no strobe on release.
REQ-025 Counters SHALL be sized $clog2(max parameter)+1 bits and SHALL saturate, never wrap.

Reset
REQ-026 While reset=0: synchronizers, debounced levels, and counters SHALL be 0; FSM SHALL be IDLE; all outputs SHALL be 0.
REQ-027 Reset asserted mid-HOLD or mid-EMIT SHALL abort immediately with no partial strobe; a button held through reset release SHALL be treated as a new press (strobe after DEBOUNCE_CYCLES+2).

Structure
REQ-028 State encoding and button index constants (BTN_FUNCT=0, BTN_AUM=1, BTN_DIS=2) SHALL reside in shared package button_pkg.
REQ-029 Synchronizer plus debouncer SHALL be sub-module debounce_sync (parameter DEBOUNCE_CYCLES), instantiated three times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5)
REQ-030 Clean aumentar press held 8 cycles -> one chip_select pulse with aumentar=1, after edge 6; none on release.
REQ-031 btn_disminuir bouncing 1-0-1-0 at 1-cycle intervals then released -> no chip_select.
REQ-032 aumentar held 30 cycles -> strobes at t0, t0+10, t0+15, t0+20, t0+25; funct held 30 cycles -> single strobe.
REQ-033 All three pressed same cycle -> single strobe with funct_select=1 only; no further strobes until all released and re-pressed.
REQ-034 reset=0 asserted during HOLD with aumentar held, released 3 cycles later -> outputs 0 during reset; new strobe after edge 6 of post-reset sampling.
REQ-035 enable=0 while disminuir held in repeat -> no further strobes; enable=1 with button still held -> no strobe until release and re-press.
